// File: rtl/icache_pkg.sv
// Shared definitions for the instruction cache: FSM encoding, default geometry
// and address-field width helpers.
package icache_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRefill,
        StResp
    } icache_state_e;

    localparam int unsigned DefLines     = 16;
    localparam int unsigned DefLineWords = 4;

    // Width of the word-offset field inside a line.
    function automatic int unsigned off_width(input int unsigned line_words);
        return $clog2(line_words);
    endfunction

    // Width of the line-index field.
    function automatic int unsigned idx_width(input int unsigned lines);
        return $clog2(lines);
    endfunction

    // Width of the tag: whatever remains above index, offset and byte bits.
    function automatic int unsigned tag_width(input int unsigned addr_w,
                                              input int unsigned lines,
                                              input int unsigned line_words);
        return addr_w - 2 - $clog2(lines) - $clog2(line_words);
    endfunction

endpackage

// File: rtl/icache_array.sv
// Tag, valid and data storage for the direct-mapped instruction cache.
// One combinational lookup port, one write port, and a clear-all for valids.
module icache_array
    import icache_pkg::*;
#(
    parameter int unsigned LINES      = DefLines,
    parameter int unsigned LINE_WORDS = DefLineWords,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned OFF_W      = off_width(LINE_WORDS),
    parameter int unsigned IDX_W      = idx_width(LINES),
    parameter int unsigned TAG_W      = 26
) (
    input  logic              clk,
    input  logic              rst,
    // lookup
    input  logic [IDX_W-1:0]  rd_idx,
    input  logic [TAG_W-1:0]  rd_tag,
    input  logic [OFF_W-1:0]  rd_off,
    output logic              hit,
    output logic [DATA_W-1:0] rd_data,
    // fill
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [OFF_W-1:0]  wr_off,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              tag_en,
    input  logic [TAG_W-1:0]  wr_tag,
    // clear every valid bit
    input  logic              inv_all
);

    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [DATA_W-1:0] data_q [LINES][LINE_WORDS];

    // Valid bits: the only reset state; clear-all wins over a line install.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (inv_all) begin
            valid_q <= '0;
        end else if (tag_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Tag and data storage, deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_q[wr_idx][wr_off] <= wr_data;
        end
        if (tag_en) begin
            tag_q[wr_idx] <= wr_tag;
        end
    end

    // Combinational lookup.
    always_comb begin
        hit     = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
        rd_data = data_q[rd_idx][rd_off];
    end

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped read-only instruction cache controller between pc_reg/id_0 and
// sim_ram. Hits answer one cycle after the request; misses stall with
// cpu_hold_o while the whole line is fetched word 0 first.
// Optional build macro ICACHE_STATS_EN adds saturating hit/miss counters.
module icache_ctrl
    import icache_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned LINES      = DefLines,
    parameter int unsigned LINE_WORDS = DefLineWords
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic              cpu_flush_i,
    input  logic              inv_i,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic [ADDR_W-1:0] cpu_addr_o,
    output logic              cpu_valid_o,
    output logic              cpu_hold_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o
`endif
);

    localparam int unsigned OFF_W = off_width(LINE_WORDS);
    localparam int unsigned IDX_W = idx_width(LINES);
    localparam int unsigned TAG_W = tag_width(ADDR_W, LINES, LINE_WORDS);
    localparam int unsigned LO    = OFF_W + 2;  // lowest index bit
    localparam int unsigned TL    = LO + IDX_W; // lowest tag bit

    icache_state_e state_q, state_d;
    logic [OFF_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:2] req_addr_q, req_addr_d;
    logic              flush_pend_q, flush_pend_d;
    logic              inv_pend_q, inv_pend_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic              arr_hit;
    logic [DATA_W-1:0] arr_rdata;
    logic              lookup_hit;
    logic              wr_en;
    logic              tag_en;
    logic              inv_all;
    logic              last_word;

    icache_array #(
        .LINES      (LINES),
        .LINE_WORDS (LINE_WORDS),
        .DATA_W     (DATA_W),
        .OFF_W      (OFF_W),
        .IDX_W      (IDX_W),
        .TAG_W      (TAG_W)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .rd_idx  (cpu_addr_i[TL-1:LO]),
        .rd_tag  (cpu_addr_i[ADDR_W-1:TL]),
        .rd_off  (cpu_addr_i[LO-1:2]),
        .hit     (arr_hit),
        .rd_data (arr_rdata),
        .wr_en   (wr_en),
        .wr_idx  (req_addr_q[TL-1:LO]),
        .wr_off  (cnt_q),
        .wr_data (mem_rdata_i),
        .tag_en  (tag_en),
        .wr_tag  (req_addr_q[ADDR_W-1:TL]),
        .inv_all (inv_all)
    );

    // A same-cycle invalidate forces the lookup to miss.
    assign lookup_hit = arr_hit && !inv_i;
    assign last_word  = (cnt_q == OFF_W'(LINE_WORDS - 1));

    // Next-state, handshake and array-control decode.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req_addr_d   = req_addr_q;
        flush_pend_d = flush_pend_q;
        inv_pend_d   = inv_pend_q;
        valid_d      = 1'b0;
        rdata_d      = rdata_q;
        addr_d       = addr_q;
        wr_en        = 1'b0;
        tag_en       = 1'b0;
        inv_all      = 1'b0;
        cpu_hold_o   = 1'b0;
        mem_req_o    = 1'b0;
        mem_addr_o   = '0;

        unique case (state_q)
            StIdle: begin
                inv_all = inv_i;
                if (cpu_req_i) begin
                    addr_d = cpu_addr_i;
                    if (lookup_hit) begin
                        valid_d = !cpu_flush_i;
                        rdata_d = arr_rdata;
                    end else begin
                        cpu_hold_o   = 1'b1;
                        req_addr_d   = cpu_addr_i[ADDR_W-1:2];
                        cnt_d        = '0;
                        flush_pend_d = 1'b0;
                        inv_pend_d   = 1'b0;
                        state_d      = StRefill;
                    end
                end
            end
            StRefill: begin
                cpu_hold_o = 1'b1;
                mem_req_o  = 1'b1;
                mem_addr_o = {req_addr_q[ADDR_W-1:LO], cnt_q, 2'b00};
                if (inv_i) begin
                    inv_pend_d = 1'b1;
                end
                if (cpu_flush_i) begin
                    flush_pend_d = 1'b1;
                end
                if (mem_ack_i) begin
                    wr_en = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    // Capture the requested word as it streams past.
                    if (cnt_q == req_addr_q[LO-1:2]) begin
                        rdata_d = mem_rdata_i;
                    end
                    if (last_word) begin
                        tag_en  = !(inv_pend_q || inv_i);
                        inv_all = inv_pend_q || inv_i;
                        if (flush_pend_q || cpu_flush_i) begin
                            state_d = StIdle;
                        end else begin
                            valid_d = 1'b1;
                            state_d = StResp;
                        end
                    end
                end
            end
            StResp: begin
                inv_all = inv_i;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            req_addr_q   <= '0;
            flush_pend_q <= 1'b0;
            inv_pend_q   <= 1'b0;
            valid_q      <= 1'b0;
            rdata_q      <= '0;
            addr_q       <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_addr_q   <= req_addr_d;
            flush_pend_q <= flush_pend_d;
            inv_pend_q   <= inv_pend_d;
            valid_q      <= valid_d;
            rdata_q      <= rdata_d;
            addr_q       <= addr_d;
        end
    end

    assign cpu_valid_o = valid_q;
    assign cpu_rdata_o = rdata_q;
    assign cpu_addr_o  = addr_q;

`ifdef ICACHE_STATS_EN
    logic        hit_evt;
    logic        miss_evt;
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    // Flushed hits are still hits.
    assign hit_evt  = (state_q == StIdle) && cpu_req_i && lookup_hit;
    assign miss_evt = (state_q == StIdle) && cpu_req_i && !lookup_hit;

    // Saturating hit/miss counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (hit_evt && (hit_cnt_q != '1)) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (miss_evt && (miss_cnt_q != '1)) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// Scoreboard bench for icache_ctrl: stimulus pushes expected responses and
// memory reads; a monitor and a memory model pop and compare independently.
module tb_icache_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic        cpu_flush;
    logic        inv;
    logic [31:0] cpu_rdata;
    logic [31:0] cpu_addr_o;
    logic        cpu_valid;
    logic        cpu_hold;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    icache_ctrl u_dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_req_i   (cpu_req),
        .cpu_addr_i  (cpu_addr),
        .cpu_flush_i (cpu_flush),
        .inv_i       (inv),
        .cpu_rdata_o (cpu_rdata),
        .cpu_addr_o  (cpu_addr_o),
        .cpu_valid_o (cpu_valid),
        .cpu_hold_o  (cpu_hold),
        .mem_req_o   (mem_req),
        .mem_addr_o  (mem_addr),
        .mem_ack_i   (mem_ack),
        .mem_rdata_i (mem_rdata)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;   // -1: any cycle
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem_exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    int          ack_num  = 0;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return 32'hA500_0000 | a;
    endfunction

    function automatic void chk(input string name, input logic ok,
                                input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, req);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // sim_ram model: ack two cycles into each word request, checks read order.
    initial begin : mem_model
        int          wcnt;
        logic [31:0] ea;
        wcnt      = 0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst || !mem_req || mem_ack) begin
                mem_ack = 1'b0;
                wcnt    = 0;
            end else begin
                wcnt++;
                if (wcnt == 2) begin
                    mem_ack   = 1'b1;
                    mem_rdata = word_of(mem_addr);
                    ack_num++;
                    ea = 32'hFFFF_FFFF;
                    if (mem_exp_q.size() > 0) ea = mem_exp_q.pop_front();
                    chk("mem_addr", mem_addr == ea, mem_addr, ea);
                end
            end
        end
    end

    // Response monitor.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (mem_req) chk("hold_in_refill", cpu_hold == 1'b1, 32'(cpu_hold), 32'd1);
                if (cpu_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_valid", 1'b0, cpu_addr_o, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_addr", cpu_addr_o == e.addr, cpu_addr_o, e.addr);
                        chk("rsp_data", cpu_rdata == e.data, cpu_rdata, e.data);
                        if (e.cyc >= 0) chk("rsp_cycle", cyc == e.cyc, 32'(cyc), 32'(e.cyc));
                    end
                end
            end
        end
    end

    // Present one request for one cycle; checks hit/miss via cpu_hold_o.
    task automatic issue(input logic [31:0] a, input bit hit, input bit rsp);
        exp_t e;
        cpu_req  = 1'b1;
        cpu_addr = a;
        #1;
        chk("hold_on_req", cpu_hold == !hit, 32'(cpu_hold), 32'(!hit));
        if (hit) chk("no_mem_on_hit", mem_req == 1'b0, 32'(mem_req), 32'd0);
        e.addr = a;
        e.data = word_of(a);
        e.cyc  = hit ? cyc + 1 : -1;
        if (rsp) exp_q.push_back(e);
        if (!hit) begin
            for (int i = 0; i < 4; i++) mem_exp_q.push_back((a & ~32'hF) + 32'(4 * i));
        end
        @(posedge clk);
        #1;
    endtask

    // Wait for the refill to finish (hold low), bounded.
    task automatic wait_idle();
        bit done;
        done    = 1'b0;
        cpu_req = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!cpu_hold) begin
                done = 1'b1;
                break;
            end
        end
        chk("refill_done", done, 32'(done), 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Wait until the n-th ack (relative to base) is on the bus, bounded.
    task automatic wait_ack(input int target, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #2;
            if (mem_ack && ack_num == target) begin
                seen = 1'b1;
                break;
            end
        end
        chk("ack_seen", seen, 32'(seen), 32'd1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        bit seen;
        int base;
        rst       = 1'b1;
        cpu_req   = 1'b0;
        cpu_addr  = '0;
        cpu_flush = 1'b0;
        inv       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", cpu_valid == 1'b0, 32'(cpu_valid), 32'd0);
        chk("rst_hold",  cpu_hold == 1'b0, 32'(cpu_hold), 32'd0);
        chk("rst_memreq", mem_req == 1'b0, 32'(mem_req), 32'd0);
        chk("rst_rdata", cpu_rdata == 32'd0, cpu_rdata, 32'd0);
        chk("rst_addr",  cpu_addr_o == 32'd0, cpu_addr_o, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Cold miss then hit stream.
        issue(32'h0, 1'b0, 1'b1);
        wait_idle();
        issue(32'h4, 1'b1, 1'b1);
        issue(32'h8, 1'b1, 1'b1);
        issue(32'hC, 1'b1, 1'b1);
        cpu_req = 1'b0;
        @(posedge clk);
        #1;

        // Conflict on index 0.
        issue(32'h100, 1'b0, 1'b1);
        wait_idle();
        issue(32'h0, 1'b0, 1'b1);
        wait_idle();

        // Flush on the second ack: line installed, no response.
        issue(32'h40, 1'b0, 1'b0);
        cpu_req = 1'b0;
        base = ack_num;
        wait_ack(base + 2, seen);
        cpu_flush = 1'b1;
        @(posedge clk);
        #1;
        cpu_flush = 1'b0;
        wait_idle();
        issue(32'h44, 1'b1, 1'b1);
        cpu_req = 1'b0;
        @(posedge clk);
        #1;

        // Invalidate during a refill: the filled line and older lines miss.
        issue(32'h208, 1'b0, 1'b1);
        cpu_req = 1'b0;
        base = ack_num;
        wait_ack(base + 1, seen);
        inv = 1'b1;
        @(posedge clk);
        #1;
        inv = 1'b0;
        wait_idle();
        issue(32'h44, 1'b0, 1'b1);
        wait_idle();
        issue(32'h0, 1'b0, 1'b1);
        wait_idle();
        issue(32'h200, 1'b0, 1'b1);
        wait_idle();

        // Reset after one ack.
        issue(32'h80, 1'b0, 1'b1);
        cpu_req = 1'b0;
        base = ack_num;
        wait_ack(base + 1, seen);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_memreq", mem_req == 1'b0, 32'(mem_req), 32'd0);
        chk("arst_hold", cpu_hold == 1'b0, 32'(cpu_hold), 32'd0);
        chk("arst_valid", cpu_valid == 1'b0, 32'(cpu_valid), 32'd0);
        exp_q.delete();
        mem_exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        issue(32'h80, 1'b0, 1'b1);
        wait_idle();

        repeat (3) @(posedge clk);
        #1;
        chk("rsp_drained", exp_q.size() == 0, 32'(exp_q.size()), 32'd0);
        chk("mem_drained", mem_exp_q.size() == 0, 32'(mem_exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
